// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

   localparam int RF_WIDTH     = 32;
   localparam int RF_DEPTH     = 32;
   localparam int RF_PAR_MAX_W = 1024;

   // Width of an entry index; a single-entry file still needs one address bit.
   function automatic int addr_width(input int depth);
      if (depth > 1) begin
         return $clog2(depth);
      end else begin
         return 1;
      end
   endfunction

   // Even parity: the returned bit makes the total count of ones even.
   // Callers zero-extend narrower data, which leaves the parity unchanged.
   function automatic logic even_parity(input logic [RF_PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: alloc marks an entry busy, a retiring write clears it,
// and alloc wins when both hit the same entry in one cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH       = RF_DEPTH,
   parameter int ADDR_WIDTH  = addr_width(RF_DEPTH),
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 2,
   parameter int ZERO_REG    = 1,
   parameter int BYPASS      = 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [WRITE_PORTS-1:0]           wr_ok_i,
   input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
   input  logic                             alloc_en_i,
   input  logic [ADDR_WIDTH-1:0]            alloc_addr_i,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
   output logic [READ_PORTS-1:0]            rd_busy_o
);

   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   logic [DEPTH-1:0]      busy_r;
   logic [DEPTH-1:0]      busy_next_s;
   logic                  alloc_ok_s;
   logic [READ_PORTS-1:0] rd_busy_s;

   // Alloc is dropped for out-of-range addresses and for the hard-wired zero entry.
   always_comb begin
      alloc_ok_s = alloc_en_i && ({1'b0, alloc_addr_i} < DEPTH_V);
      if ((ZERO_REG != 0) && (alloc_addr_i == {AW{1'b0}})) begin
         alloc_ok_s = 1'b0;
      end else begin
         alloc_ok_s = alloc_ok_s;
      end
   end

   // Next busy state: clears from writes first, then alloc sets on top.
   always_comb begin
      busy_next_s = busy_r;
      for (int e = 0; e < DEPTH; e++) begin
         for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_ok_i[w] && (wr_addr_i[w*AW +: AW] == AW'(e))) begin
               busy_next_s[e] = 1'b0;
            end else begin
               busy_next_s[e] = busy_next_s[e];
            end
         end
         if (alloc_ok_s && (alloc_addr_i == AW'(e))) begin
            busy_next_s[e] = 1'b1;
         end else begin
            busy_next_s[e] = busy_next_s[e];
         end
      end
      if (ZERO_REG != 0) begin
         busy_next_s[0] = 1'b0;
      end else begin
         busy_next_s[0] = busy_next_s[0];
      end
   end

   // Busy-bit storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_next_s;
      end
   end

   // Per-port lookup; a write retiring this cycle hides the busy bit when forwarding.
   always_comb begin
      rd_busy_s = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (rd_addr_i[p*AW +: AW] == AW'(e)) begin
               rd_busy_s[p] = busy_r[e];
            end else begin
               rd_busy_s[p] = rd_busy_s[p];
            end
         end
         for (int w = 0; w < WRITE_PORTS; w++) begin
            if ((BYPASS != 0) && wr_ok_i[w] &&
                (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
               rd_busy_s[p] = 1'b0;
            end else begin
               rd_busy_s[p] = rd_busy_s[p];
            end
         end
         if ((ZERO_REG != 0) && (rd_addr_i[p*AW +: AW] == {AW{1'b0}})) begin
            rd_busy_s[p] = 1'b0;
         end else begin
            rd_busy_s[p] = rd_busy_s[p];
         end
      end
   end

   assign rd_busy_o = rd_busy_s;

endmodule

// File: rtl/regfile_mp.sv
// Multi-write/multi-read register file with bypass, busy scoreboard and
// write-conflict flag. Optional per-entry parity under REGFILE_PARITY_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH       = RF_WIDTH,
   parameter int DEPTH       = RF_DEPTH,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 2,
   parameter int ZERO_REG    = 1,
   parameter int BYPASS      = 1,
   localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [WRITE_PORTS-1:0]            wr_en_i,
   input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [WRITE_PORTS*WIDTH-1:0]      wr_data_i,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0]  rd_addr_i,
   output logic [READ_PORTS*WIDTH-1:0]       rd_data_o,
   output logic [READ_PORTS-1:0]             rd_busy_o,
   input  logic                              alloc_en_i,
   input  logic [ADDR_WIDTH-1:0]             alloc_addr_i,
   output logic                              conflict_o,
   output logic [READ_PORTS-1:0]             perr_o
);

   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_r;
   logic [DEPTH-1:0][WIDTH-1:0] mem_next_s;
   logic [WRITE_PORTS-1:0]      wr_ok_s;
   logic                        conflict_s;
   logic                        conflict_r;
   logic [WIDTH-1:0]            array_rd_s [READ_PORTS];
   logic [WIDTH-1:0]            byp_data_s [READ_PORTS];
   logic [READ_PORTS-1:0]       bypassed_s;
   logic [READ_PORTS*WIDTH-1:0] rd_data_s;

   // Effective write enables; gating on rst_ni keeps bypass quiet while reset is held.
   always_comb begin
      wr_ok_s = '0;
      for (int w = 0; w < WRITE_PORTS; w++) begin
         if (rst_ni && wr_en_i[w] && ({1'b0, wr_addr_i[w*AW +: AW]} < DEPTH_V) &&
             !((ZERO_REG != 0) && (wr_addr_i[w*AW +: AW] == {AW{1'b0}}))) begin
            wr_ok_s[w] = 1'b1;
         end else begin
            wr_ok_s[w] = 1'b0;
         end
      end
   end

   // Array update; ascending port order lets the highest index win.
   always_comb begin
      mem_next_s = mem_r;
      for (int e = 0; e < DEPTH; e++) begin
         for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_ok_s[w] && (wr_addr_i[w*AW +: AW] == AW'(e))) begin
               mem_next_s[e] = wr_data_i[w*WIDTH +: WIDTH];
            end else begin
               mem_next_s[e] = mem_next_s[e];
            end
         end
      end
   end

   // Any pair of effective writes to one address is a conflict.
   always_comb begin
      conflict_s = 1'b0;
      for (int i = 0; i < WRITE_PORTS; i++) begin
         for (int j = i + 1; j < WRITE_PORTS; j++) begin
            if (wr_ok_s[i] && wr_ok_s[j] &&
                (wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW])) begin
               conflict_s = 1'b1;
            end else begin
               conflict_s = conflict_s;
            end
         end
      end
   end

   // Data array and conflict pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_r      <= '0;
         conflict_r <= 1'b0;
      end else begin
         mem_r      <= mem_next_s;
         conflict_r <= conflict_s;
      end
   end

   // Read path: stored value first, then same-cycle forwarding overrides it.
   always_comb begin
      rd_data_s  = '0;
      bypassed_s = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         array_rd_s[p] = '0;
         byp_data_s[p] = '0;
         for (int e = 0; e < DEPTH; e++) begin
            if (rd_addr_i[p*AW +: AW] == AW'(e)) begin
               array_rd_s[p] = mem_r[e];
            end else begin
               array_rd_s[p] = array_rd_s[p];
            end
         end
         if ((ZERO_REG != 0) && (rd_addr_i[p*AW +: AW] == {AW{1'b0}})) begin
            array_rd_s[p] = '0;
         end else begin
            array_rd_s[p] = array_rd_s[p];
         end
         for (int w = 0; w < WRITE_PORTS; w++) begin
            if ((BYPASS != 0) && wr_ok_s[w] &&
                (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
               byp_data_s[p] = wr_data_i[w*WIDTH +: WIDTH];
               bypassed_s[p] = 1'b1;
            end else begin
               byp_data_s[p] = byp_data_s[p];
               bypassed_s[p] = bypassed_s[p];
            end
         end
         rd_data_s[p*WIDTH +: WIDTH] = bypassed_s[p] ? byp_data_s[p] : array_rd_s[p];
      end
   end

   assign rd_data_o  = rd_data_s;
   assign conflict_o = conflict_r;

`ifdef REGFILE_PARITY_EN
   logic [DEPTH-1:0]      par_r;
   logic [DEPTH-1:0]      par_next_s;
   logic                  array_par_s [READ_PORTS];
   logic [READ_PORTS-1:0] perr_s;

   // Parity computed from the same data that lands in the array.
   always_comb begin
      par_next_s = par_r;
      for (int e = 0; e < DEPTH; e++) begin
         if (mem_next_s[e] != mem_r[e] || wr_hit(e)) begin
            par_next_s[e] = even_parity(RF_PAR_MAX_W'(mem_next_s[e]));
         end else begin
            par_next_s[e] = par_next_s[e];
         end
      end
   end

   function automatic logic wr_hit(input int e);
      logic hit;
      hit = 1'b0;
      for (int w = 0; w < WRITE_PORTS; w++) begin
         if (wr_ok_s[w] && (wr_addr_i[w*AW +: AW] == AW'(e))) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
      return hit;
   endfunction

   // Parity storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         par_r <= '0;
      end else begin
         par_r <= par_next_s;
      end
   end

   // Check stored data against stored parity; forwarded data is never flagged.
   always_comb begin
      perr_s = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         array_par_s[p] = 1'b0;
         for (int e = 0; e < DEPTH; e++) begin
            if (rd_addr_i[p*AW +: AW] == AW'(e)) begin
               array_par_s[p] = par_r[e];
            end else begin
               array_par_s[p] = array_par_s[p];
            end
         end
         if ((ZERO_REG != 0) && (rd_addr_i[p*AW +: AW] == {AW{1'b0}})) begin
            array_par_s[p] = 1'b0;
         end else begin
            array_par_s[p] = array_par_s[p];
         end
         if (!bypassed_s[p] &&
             (even_parity(RF_PAR_MAX_W'(array_rd_s[p])) != array_par_s[p])) begin
            perr_s[p] = 1'b1;
         end else begin
            perr_s[p] = 1'b0;
         end
      end
   end

   assign perr_o = perr_s;
`else
   assign perr_o = '0;
`endif

   regfile_scoreboard #(
      .DEPTH       (DEPTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .READ_PORTS  (READ_PORTS),
      .WRITE_PORTS (WRITE_PORTS),
      .ZERO_REG    (ZERO_REG),
      .BYPASS      (BYPASS)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wr_ok_i      (wr_ok_s),
      .wr_addr_i    (wr_addr_i),
      .alloc_en_i   (alloc_en_i),
      .alloc_addr_i (alloc_addr_i),
      .rd_addr_i    (rd_addr_i),
      .rd_busy_o    (rd_busy_o)
   );

endmodule
